// File: rtl/pc_gen_pkg.sv
// Shared types, constants and BTB sizing helpers for the PC generator.
package pc_gen_pkg;

  localparam int unsigned StallW    = 6;
  localparam int unsigned InstAddrW = 32;

  typedef logic [StallW-1:0]    StallBus;
  typedef logic [InstAddrW-1:0] InstAddrBus;

  localparam logic RstEnable = 1'b1;

  function automatic int unsigned btb_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Tag covers everything above the word offset and the index field.
  function automatic int unsigned btb_tag_w(input int unsigned addr_w, input int unsigned depth);
    return addr_w - 2 - $clog2(depth);
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered write, reset clears valids.
module pc_btb
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic              hit,
  output logic [ADDR_W-1:0] target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic [ADDR_W-1:0] upd_target
);

  localparam int unsigned IdxW = btb_idx_w(DEPTH);
  localparam int unsigned TagW = btb_tag_w(ADDR_W, DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [TagW-1:0]   tag_q    [DEPTH];
  logic [TagW-1:0]   tag_d    [DEPTH];
  logic [ADDR_W-1:0] target_q [DEPTH];
  logic [ADDR_W-1:0] target_d [DEPTH];

  logic [IdxW-1:0] lk_idx, upd_idx;
  logic [TagW-1:0] lk_tag, upd_tag;
  logic            unused_lo;

  assign lk_idx    = lookup_pc[2 +: IdxW];
  assign lk_tag    = lookup_pc[ADDR_W-1 -: TagW];
  assign upd_idx   = upd_pc[2 +: IdxW];
  assign upd_tag   = upd_pc[ADDR_W-1 -: TagW];
  assign unused_lo = ^{lookup_pc[1:0], upd_pc[1:0]};

  // Lookup reads the stored arrays, so a same-cycle write is not visible yet.
  assign hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign target = target_q[lk_idx];

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (upd_valid) begin
      valid_d[upd_idx]  = 1'b1;
      tag_d[upd_idx]    = upd_tag;
      target_d[upd_idx] = upd_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with prioritised redirects and optional BTB (enable with PC_GEN_BTB_EN).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int unsigned       NUM_REDIR = 2,
  parameter int unsigned       BTB_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  StallBus                     stall_state,
  input  logic                        fetch_ready,
  input  logic [NUM_REDIR-1:0]        redir_valid,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_pc,
  input  logic                        upd_valid,
  input  logic [ADDR_W-1:0]           upd_pc,
  input  logic [ADDR_W-1:0]           upd_target,
  output logic [ADDR_W-1:0]           pc,
  output logic                        pc_valid,
  output logic                        pred_taken,
  output logic [15:0]                 redir_cnt
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q, pc_valid_d;
  logic [15:0]       redir_cnt_q, redir_cnt_d;
  logic [ADDR_W-1:0] redir_tgt, btb_target;
  logic              btb_hit, redir_any, advance;
  logic              unused_bits;

`ifdef PC_GEN_BTB_EN
  pc_btb #(
    .ADDR_W(ADDR_W),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (pc_q),
    .hit       (btb_hit),
    .target    (btb_target),
    .upd_valid (upd_valid),
    .upd_pc    (upd_pc),
    .upd_target(upd_target)
  );
  assign unused_bits = ^{stall_state[StallW-1:1], redir_tgt[1:0]};
`else
  assign btb_hit     = 1'b0;
  assign btb_target  = '0;
  assign unused_bits = ^{stall_state[StallW-1:1], redir_tgt[1:0], upd_valid, upd_pc, upd_target};
`endif

  // Scan from the top so the lowest asserted channel is the last to write.
  always_comb begin
    redir_tgt = '0;
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid[i]) redir_tgt = redir_pc[i*ADDR_W +: ADDR_W];
    end
  end

  assign redir_any = |redir_valid;
  assign advance   = pc_valid_q & fetch_ready & ~stall_state[0];

  always_comb begin
    pc_d        = pc_q;
    pc_valid_d  = 1'b1;
    redir_cnt_d = redir_cnt_q;
    if (redir_any) begin
      pc_d = {redir_tgt[ADDR_W-1:2], 2'b00};
      if (redir_cnt_q != 16'hFFFF) redir_cnt_d = redir_cnt_q + 16'd1;
    end else if (advance) begin
      pc_d = btb_hit ? btb_target : pc_q + ADDR_W'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      pc_q        <= RESET_PC;
      pc_valid_q  <= 1'b0;
      redir_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign pc         = pc_q;
  assign pc_valid   = pc_valid_q;
  assign pred_taken = btb_hit;
  assign redir_cnt  = redir_cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen; BTB scenarios run when PC_GEN_BTB_EN is defined.
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  StallBus     stall_state;
  logic        fetch_ready;
  logic [1:0]  redir_valid;
  logic [63:0] redir_pc;
  logic        upd_valid;
  InstAddrBus  upd_pc, upd_target;
  InstAddrBus  pc;
  logic        pc_valid, pred_taken;
  logic [15:0] redir_cnt;

  int checks = 0;
  int errors = 0;

  pc_gen #(
    .ADDR_W   (32),
    .RESET_PC (32'h0),
    .NUM_REDIR(2),
    .BTB_DEPTH(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_state(stall_state),
    .fetch_ready(fetch_ready),
    .redir_valid(redir_valid),
    .redir_pc   (redir_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .pred_taken (pred_taken),
    .redir_cnt  (redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_state = '0;
    fetch_ready = 1'b1;
    redir_valid = 2'b00;
    redir_pc    = '0;
    upd_valid   = 1'b0;
    upd_pc      = '0;
    upd_target  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want %h", pc, 32'h0); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", pc_valid); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL rst_pred: got %b want 0", pred_taken); end
    checks++; if (redir_cnt !== 16'h0) begin errors++; $display("FAIL rst_cnt: got %h want 0", redir_cnt); end
  endtask

  task automatic test_advance();
    rst = 1'b0;
    tick();
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL adv_valid: got %b want 1", pc_valid); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL adv_pc0: got %h want %h", pc, 32'h0); end
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL adv_pc4: got %h want %h", pc, 32'h4); end
    tick();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL adv_pc8: got %h want %h", pc, 32'h8); end
  endtask

  task automatic test_stall();
    tick();
    tick();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_pre: got %h want %h", pc, 32'h10); end
    stall_state = 6'b000001;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (pc !== 32'h10) begin errors++; $display("FAIL stall_hold%0d: got %h want %h", i, pc, 32'h10); end
    end
    stall_state = '0;
    tick();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL stall_rel: got %h want %h", pc, 32'h14); end
    fetch_ready = 1'b0;
    tick();
    checks++; if (pc !== 32'h14) begin errors++; $display("FAIL notready_hold: got %h want %h", pc, 32'h14); end
    // Only bit 0 of the stall vector holds the PC.
    fetch_ready = 1'b1;
    stall_state = 6'b000010;
    tick();
    checks++; if (pc !== 32'h18) begin errors++; $display("FAIL stall_bit1: got %h want %h", pc, 32'h18); end
    stall_state = '0;
  endtask

  task automatic test_redirect();
    stall_state = 6'b000001;
    redir_valid = 2'b11;
    redir_pc    = {32'h200, 32'h100};
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redir_prio: got %h want %h", pc, 32'h100); end
    checks++; if (redir_cnt !== 16'd1) begin errors++; $display("FAIL redir_cnt1: got %h want 1", redir_cnt); end
    redir_valid = 2'b00;
    tick();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL redir_stall_hold: got %h want %h", pc, 32'h100); end
    stall_state = '0;
    fetch_ready = 1'b0;
    redir_valid = 2'b10;
    redir_pc    = {32'h203, 32'h0};
    tick();
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL redir_align: got %h want %h", pc, 32'h200); end
    checks++; if (redir_cnt !== 16'd2) begin errors++; $display("FAIL redir_cnt2: got %h want 2", redir_cnt); end
    checks++; if (pc_valid !== 1'b1) begin errors++; $display("FAIL redir_valid: got %b want 1", pc_valid); end
  endtask

  task automatic test_wrap();
    redir_valid = 2'b01;
    redir_pc    = {32'h0, 32'hFFFF_FFFC};
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre: got %h want %h", pc, 32'hFFFF_FFFC); end
    redir_valid = 2'b00;
    fetch_ready = 1'b1;
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap: got %h want %h", pc, 32'h0); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL wrap_pred: got %b want 0", pred_taken); end
  endtask

  task automatic test_reset_mid();
    stall_state = 6'b000001;
    redir_valid = 2'b01;
    redir_pc    = {32'h0, 32'h300};
    rst = 1'b1;
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL midrst_pc: got %h want %h", pc, 32'h0); end
    checks++; if (redir_cnt !== 16'h0) begin errors++; $display("FAIL midrst_cnt: got %h want 0", redir_cnt); end
    checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", pc_valid); end
    idle_inputs();
    rst = 1'b0;
    tick();
  endtask

`ifdef PC_GEN_BTB_EN
  task automatic redirect_to(input InstAddrBus tgt);
    stall_state = 6'b000001;
    redir_valid = 2'b01;
    redir_pc    = {32'h0, tgt};
    tick();
    redir_valid = 2'b00;
  endtask

  task automatic test_btb_hit();
    upd_valid  = 1'b1;
    upd_pc     = 32'h40;
    upd_target = 32'h80;
    tick();
    upd_valid = 1'b0;
    redirect_to(32'h40);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL btb_pred: got %b want 1", pred_taken); end
    stall_state = '0;
    tick();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL btb_target: got %h want %h", pc, 32'h80); end
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL btb_alias: got %b want 0", pred_taken); end
  endtask

  task automatic test_btb_reset_and_same_cycle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    redirect_to(32'h40);
    stall_state = '0;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL btb_cleared_pred: got %b want 0", pred_taken); end
    tick();
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL btb_cleared_pc: got %h want %h", pc, 32'h44); end
    redirect_to(32'h40);
    stall_state = '0;
    upd_valid   = 1'b1;
    upd_pc      = 32'h40;
    upd_target  = 32'h80;
    #1;
    checks++; if (pred_taken !== 1'b0) begin errors++; $display("FAIL btb_same_pred: got %b want 0", pred_taken); end
    tick();
    upd_valid = 1'b0;
    checks++; if (pc !== 32'h44) begin errors++; $display("FAIL btb_same_pc: got %h want %h", pc, 32'h44); end
    redirect_to(32'h40);
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL btb_after_pred: got %b want 1", pred_taken); end
    stall_state = '0;
    tick();
    checks++; if (pc !== 32'h80) begin errors++; $display("FAIL btb_after_pc: got %h want %h", pc, 32'h80); end
  endtask
`endif

  task automatic test_saturate();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
    redir_valid = 2'b01;
    redir_pc    = {32'h0, 32'h500};
    for (int i = 0; i < 65535; i++) tick();
    checks++; if (redir_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h want FFFF", redir_cnt); end
    tick();
    tick();
    checks++; if (redir_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want FFFF", redir_cnt); end
    checks++; if (pc !== 32'h500) begin errors++; $display("FAIL sat_pc: got %h want %h", pc, 32'h500); end
    redir_valid = 2'b00;
  endtask

  initial begin
    test_reset();
    test_advance();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
`ifdef PC_GEN_BTB_EN
    test_btb_hit();
    test_btb_reset_and_same_cycle();
`endif
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
